// File: rtl/uart_mem_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the byte-command memory controller.
package uart_mem_ctrl_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK  = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h3F;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA,
        ST_WRITE,
        ST_MEM_RD,
        ST_TX
    } state_e;

    // Number of big-endian address bytes needed to carry an address of the given width.
    function automatic int unsigned addr_bytes(input int unsigned addr_width);
        return (addr_width + 7) / 8;
    endfunction

endpackage

// File: rtl/uart_mem_ctrl_if.sv
// Receive strobe and transmit handshake between the UART pair and the memory controller.
interface uart_mem_ctrl_if;

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       tx_valid;
    logic [7:0] tx_byte;
    logic       tx_ready;

    modport slave (
        input  rx_valid,
        input  rx_byte,
        input  tx_ready,
        output tx_valid,
        output tx_byte
    );

    modport master (
        output rx_valid,
        output rx_byte,
        output tx_ready,
        input  tx_valid,
        input  tx_byte
    );

endinterface

// File: rtl/uart_mem_ctrl_mem_ram.sv
// Single-port synchronous RAM with registered read data (one-cycle read latency).
module uart_mem_ctrl_mem_ram #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Write when enabled; always register the addressed word (contents are not reset).
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata_q <= mem[addr];
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/uart_mem_ctrl.sv
// Byte-command memory controller: parses W/R commands from the UART receiver,
// accesses the internal RAM and streams responses to the UART transmitter.
module uart_mem_ctrl
    import uart_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_BYTES = 1,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic            clock,
    input  logic            reset_n,
    uart_mem_ctrl_if.slave  bus,
    output logic            busy,
    output logic            overrun
);

    localparam int unsigned DW = 8 * DATA_BYTES;
    localparam int unsigned AB = addr_bytes(ADDR_WIDTH);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DW-1:0]         data_q, data_d;
    logic [DW-1:0]         tx_q, tx_d;
    logic [DW-1:0]         rdata;
    logic [2:0]            cnt_q, cnt_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  write_q, write_d;
    logic                  overrun_q, overrun_d;
    logic                  ram_we;

    // Next-state, shift registers, timeout and dropped-byte detection.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        data_d    = data_q;
        tx_d      = tx_q;
        cnt_d     = cnt_q;
        to_d      = '0;
        write_d   = write_q;
        overrun_d = 1'b0;
        ram_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == OP_WRITE || bus.rx_byte == OP_READ) begin
                        write_d = (bus.rx_byte == OP_WRITE);
                        cnt_d   = 3'(AB - 1);
                        state_d = ST_ADDR;
                    end else begin
                        tx_d    = DW'(RSP_ERR) << (DW - 8);
                        cnt_d   = '0;
                        state_d = ST_TX;
                    end
                end
            end
            ST_ADDR: begin
                if (bus.rx_valid) begin
                    // Shifting within ADDR_WIDTH bits drops excess high address bits.
                    addr_d = (addr_q << 8) | ADDR_WIDTH'(bus.rx_byte);
                    if (cnt_q == '0) begin
                        if (write_q) begin
                            cnt_d   = 3'(DATA_BYTES - 1);
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_MEM_RD;
                        end
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (bus.rx_valid) begin
                    data_d = (data_q << 8) | DW'(bus.rx_byte);
                    if (cnt_q == '0) begin
                        state_d = ST_WRITE;
                    end else begin
                        cnt_d = cnt_q - 3'd1;
                    end
                end else if (to_q == TO_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            ST_WRITE: begin
                ram_we    = 1'b1;
                overrun_d = bus.rx_valid;
                tx_d      = DW'(RSP_ACK) << (DW - 8);
                cnt_d     = '0;
                state_d   = ST_TX;
            end
            ST_MEM_RD: begin
                overrun_d = bus.rx_valid;
                tx_d      = rdata;
                cnt_d     = 3'(DATA_BYTES - 1);
                state_d   = ST_TX;
            end
            ST_TX: begin
                overrun_d = bus.rx_valid;
                if (bus.tx_ready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        tx_d  = tx_q << 8;
                        cnt_d = cnt_q - 3'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            data_q    <= '0;
            tx_q      <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            write_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            write_q   <= write_d;
            overrun_q <= overrun_d;
        end
    end

    // The RAM sees the next address so a read launches on the last address
    // byte; the word is then ready to load into tx_q when leaving MEM_RD.
    uart_mem_ctrl_mem_ram #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DW)
    ) u_ram (
        .clock (clock),
        .we    (ram_we),
        .addr  (addr_d),
        .wdata (data_q),
        .rdata (rdata)
    );

    assign bus.tx_valid = (state_q == ST_TX);
    assign bus.tx_byte  = tx_q[DW-1 -: 8];
    assign busy         = (state_q != ST_IDLE);
    assign overrun      = overrun_q;

endmodule

// File: doc/uart_mem_ctrl.md
Name: uart_mem_ctrl

Overview:
- Byte-command memory controller: parses a command stream from the UART receiver, performs word reads/writes on an internal parametrised RAM, and returns responses to the UART transmitter.
- Successor to the fixed 256x8 byte memory. Adds configurable address width and data word width, a command protocol, an inter-byte timeout and a transmit handshake.
- Sits between uart_rx and uart_tx in the host-access path.

Parameters:
ADDR_WIDTH, 8, RAM address bits; DEPTH = 2**ADDR_WIDTH; range 1..16
DATA_BYTES, 1, bytes per RAM word; range 1..4; word width = 8*DATA_BYTES
TIMEOUT, 100000, clock cycles allowed between bytes of one command before abort; must be >= 2

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
rx_valid  in  1  one-cycle strobe: rx_byte is valid
rx_byte  in  8  received byte
tx_valid  out  1  tx_byte is valid; held until accepted
tx_byte  out  8  byte to transmit
tx_ready  in  1  transmitter accepts tx_byte on an edge where tx_valid && tx_ready
busy  out  1  high in any state other than IDLE
overrun  out  1  one-cycle pulse: an rx byte was dropped

Behaviour:
- Reset (async, reset_n=0): state IDLE; tx_valid=0, tx_byte=0, busy=0, overrun=0; timeout counter 0. RAM contents are not reset.
- ADDR_BYTES = ceil(ADDR_WIDTH/8). Multi-byte fields are big-endian. Address bits above ADDR_WIDTH are ignored (truncation, no error).
- Commands:
  - 0x57 'W' + ADDR_BYTES address + DATA_BYTES data -> write, then respond 0x4B 'K'.
  - 0x52 'R' + ADDR_BYTES address -> respond DATA_BYTES data bytes, MSB first.
  - Any other first byte -> respond 0x3F '?'.
- States:
  - IDLE: on rx_valid, decode the byte -> ADDR ('W'/'R') or TX with '?'.
  - ADDR: shift in address bytes. After the last byte: 'W' -> DATA; 'R' -> MEM_RD.
  - DATA: shift in data bytes. After the last byte, a one-cycle RAM write (WRITE) -> TX with 'K'.
  - MEM_RD: RAM read issued; data registered 1 cycle later into the tx shift register -> TX.
  - TX: tx_valid=1. Each accepted byte loads the next. After the last accepted byte -> IDLE with tx_valid=0 the same edge.
- Latency:
  - Write: last data byte strobe -> WRITE state (RAM updated at the following edge) -> tx_valid high 2 cycles after the strobe.
  - Read: last address byte strobe -> tx_valid high 2 cycles after the strobe.
  - Bad opcode: tx_valid high 1 cycle after the strobe.
- Handshake:
  - tx_byte is stable while tx_valid=1 and tx_ready=0.
  - tx_ready asserted in the same cycle tx_valid rises is a valid acceptance.
  - tx_ready while tx_valid=0 is ignored.
- Dropped bytes: rx_valid in WRITE, MEM_RD or TX drops the byte and pulses overrun for 1 cycle. There is no queueing.
- Timeout:
  - In ADDR/DATA the counter increments each cycle and clears on each rx_valid.
  - When it reaches TIMEOUT-1, go to IDLE silently: no response, partial command discarded, RAM unchanged.
  - If rx_valid arrives in that same cycle, the byte is accepted and the counter clears (byte wins).
- Reset mid-command or mid-TX: immediate return to IDLE with tx_valid=0. A RAM write is committed only in the WRITE state.
- Read-after-write to the same address returns the new data.

Decomposition:
- Shared package: opcode constants OP_WRITE=0x57, OP_READ=0x52; response constants RSP_ACK=0x4B, RSP_ERR=0x3F; state enumeration; ADDR_BYTES derivation function.
- One sub-module: mem_ram (parametrised single-port synchronous RAM; write-enable, registered read data, 1-cycle read latency). The controller holds the FSM, shift registers and timeout counter.

Test Plan:
- ADDR_WIDTH=8, DATA_BYTES=1, tx_ready=1: send 57 0A 07 -> tx 4B; then 52 0A -> tx 07; then 57 0B 06 / 52 0B -> 4B then 06.
- ADDR_WIDTH=12, DATA_BYTES=2: send 57 0F FF BE EF, then 52 0F FF -> 4B then BE, EF. Then 52 FF FF -> BE, EF (upper address bits truncated).
- Bad opcode 0x41 -> tx 3F one cycle after the strobe; busy returns to 0 after acceptance.
- Backpressure: read with tx_ready low 5 cycles -> tx_valid and tx_byte held constant; byte accepted on the first cycle with tx_ready=1; an rx_valid during TX -> overrun pulse, state unaffected.
- TIMEOUT=8: send 57 0A, then idle 8 cycles -> busy falls, no tx. Follow with 52 0A -> prior contents returned (no write occurred).
- Assert reset_n=0 while in DATA and while in TX -> outputs return to reset values immediately; the next full command executes normally.
